three_to_eight_decoder: RTL and testbench

THREE_TO_EIGHT_DECODER -- requirements
Module: three_to_eight_decoder

---
 rtl/decoder_pkg.sv | 13 +
 rtl/three_to_eight_decoder_if.sv | 22 ++
 rtl/onehot3to8.sv | 13 +
 rtl/three_to_eight_decoder.sv | 92 +++++++++
 tb/tb_three_to_eight_decoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 decoder: FSM state encoding and bus widths.
package decoder_pkg;

    localparam int CODE_W  = 3;
    localparam int OUT_W   = 8;
    localparam int COUNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/three_to_eight_decoder_if.sv
// Code-in / decode-out signal bundle for the 3-to-8 decoder.
interface three_to_eight_decoder_if;
    import decoder_pkg::*;

    logic [CODE_W-1:0]  three_input;
    logic               V_in;
    logic               in_ready;
    logic [OUT_W-1:0]   eight_output;
    logic               V;
    logic [COUNT_W-1:0] event_count;

    modport master (
        output three_input, V_in,
        input  in_ready, eight_output, V, event_count
    );

    modport slave (
        input  three_input, V_in,
        output in_ready, eight_output, V, event_count
    );

endinterface

// File: rtl/onehot3to8.sv
// Purely combinational binary-to-one-hot mapping; exactly one output bit is set.
module onehot3to8
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [OUT_W-1:0]  onehot_o
);

    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
        assign onehot_o[gi] = (code_i == CODE_W'(gi));
    end

endmodule

// File: rtl/three_to_eight_decoder.sv
// Handshaked 3-to-8 decoder: an accepted code is shown one-hot for HOLD_CYCLES
// cycles; a new code may be taken on the last hold cycle for gapless output.
module three_to_eight_decoder
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CODE_W-1:0]  three_input,
    input  logic               V_in,
    output logic               in_ready,
    output logic [OUT_W-1:0]   eight_output,
    output logic               V,
    output logic [COUNT_W-1:0] event_count
);

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0]   out_q;
    logic               v_q;
    logic [OUT_W-1:0]   onehot_d;
    logic               accept;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        code_d     = code_q;
        count_d    = count_q;
        in_ready   = (state_q == IDLE) || (hold_cnt_q == 8'd0);
        accept     = V_in && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = HOLD;
                    code_d     = three_input;
                    hold_cnt_d = HOLD_RELOAD;
                end
            end
            HOLD: begin
                if (hold_cnt_q != 8'd0) begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end else if (accept) begin
                    code_d     = three_input;
                    hold_cnt_d = HOLD_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            count_d = count_q + 8'd1;
        end
    end

    // Decode the next-state code so the output register lines up with the
    // state register, giving one cycle from acceptance to visible output.
    onehot3to8 u_onehot (
        .code_i   (code_d),
        .onehot_o (onehot_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            code_q     <= '0;
            count_q    <= '0;
            out_q      <= '0;
            v_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            code_q     <= code_d;
            count_q    <= count_d;
            out_q      <= (state_d == HOLD) ? onehot_d : '0;
            v_q        <= (state_d == HOLD);
        end
    end

    assign eight_output = out_q;
    assign V            = v_q;
    assign event_count  = count_q;

endmodule

// File: tb/tb_three_to_eight_decoder.sv
// Scoreboard bench: stimulus queues expected decodes, a negedge monitor checks them.
module tb_three_to_eight_decoder;
    import decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst1;
    three_to_eight_decoder_if if4 ();
    three_to_eight_decoder_if if1 ();

    three_to_eight_decoder #(.HOLD_CYCLES(4)) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .three_input  (if4.three_input),
        .V_in         (if4.V_in),
        .in_ready     (if4.in_ready),
        .eight_output (if4.eight_output),
        .V            (if4.V),
        .event_count  (if4.event_count)
    );

    three_to_eight_decoder #(.HOLD_CYCLES(1)) dut1 (
        .clk          (clk),
        .rst          (rst1),
        .three_input  (if1.three_input),
        .V_in         (if1.V_in),
        .in_ready     (if1.in_ready),
        .eight_output (if1.eight_output),
        .V            (if1.V),
        .event_count  (if1.event_count)
    );

    logic [7:0] q4[$];
    logic [7:0] q1[$];
    logic [7:0] e4, e1;
    int  n_pass  = 0;
    int  n_total = 0;
    bit  mon_en  = 1'b0;
    int  exp_cnt4 = 0;
    logic [7:0] exp_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (if4.V === 1'b1) begin
                if (q4.size() == 0) chk("d4_extra_V", 32'(if4.V), 32'd0);
                else begin
                    e4 = q4.pop_front();
                    chk("d4_out", 32'(if4.eight_output), 32'(e4));
                end
            end else begin
                chk("d4_idle_out", 32'(if4.eight_output), 32'd0);
            end
            if (if1.V === 1'b1) begin
                if (q1.size() == 0) chk("d1_extra_V", 32'(if1.V), 32'd0);
                else begin
                    e1 = q1.pop_front();
                    chk("d1_out", 32'(if1.eight_output), 32'(e1));
                end
            end else begin
                chk("d1_idle_out", 32'(if1.eight_output), 32'd0);
            end
        end
    end

    initial begin
        rst4 = 1'b1; rst1 = 1'b1;
        if4.three_input = '0; if4.V_in = 1'b0;
        if1.three_input = '0; if1.V_in = 1'b0;
        tick(); tick();
        rst4 = 1'b0; rst1 = 1'b0;
        mon_en = 1'b1;
        chk("rst_out",   32'(if4.eight_output), 32'h00);
        chk("rst_V",     32'(if4.V),            32'd0);
        chk("rst_ready", 32'(if4.in_ready),     32'd1);
        chk("rst_count", 32'(if4.event_count),  32'd0);
        chk("rst1_ready", 32'(if1.in_ready),    32'd1);
        chk("rst1_count", 32'(if1.event_count), 32'd0);

        // single decodes, each code once
        for (int c = 0; c < 8; c++) begin
            if4.three_input = 3'(c);
            if4.V_in = 1'b1;
            repeat (4) q4.push_back(exp_tab[c]);
            exp_cnt4++;
            $display("txn dut4 single code=%0d expect=%02h", c, exp_tab[c]);
            tick();
            if4.V_in = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk("single_V",   32'(if4.V),            32'd1);
                chk("single_out", 32'(if4.eight_output), 32'(exp_tab[c]));
                tick();
            end
            chk("single_end_V",   32'(if4.V),            32'd0);
            chk("single_end_out", 32'(if4.eight_output), 32'h00);
            chk("single_count",   32'(if4.event_count),  32'(exp_cnt4));
        end

        // back-to-back 3 then 6
        rst4 = 1'b1; tick(); rst4 = 1'b0; exp_cnt4 = 0;
        if4.three_input = 3'd3; if4.V_in = 1'b1;
        repeat (4) q4.push_back(8'h08);
        $display("txn dut4 b2b code=3 expect=08");
        tick();
        if4.three_input = 3'd6;
        repeat (4) q4.push_back(8'h40);
        $display("txn dut4 b2b code=6 expect=40");
        for (int k = 0; k < 4; k++) begin
            chk("b2b_V_a",   32'(if4.V),            32'd1);
            chk("b2b_out_a", 32'(if4.eight_output), 32'h08);
            chk("b2b_ready", 32'(if4.in_ready),     (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        if4.V_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_V_b",   32'(if4.V),            32'd1);
            chk("b2b_out_b", 32'(if4.eight_output), 32'h40);
            tick();
        end
        chk("b2b_end_V", 32'(if4.V),           32'd0);
        chk("b2b_count", 32'(if4.event_count), 32'd2);
        exp_cnt4 = 2;

        // code 5 offered while busy holding code 1
        if4.three_input = 3'd1; if4.V_in = 1'b1;
        repeat (4) q4.push_back(8'h02);
        exp_cnt4++;
        $display("txn dut4 hold code=1 expect=02");
        tick();
        if4.three_input = 3'd5;
        chk("ign_ready", 32'(if4.in_ready), 32'd0);
        $display("txn dut4 ignored code=5");
        tick();
        if4.V_in = 1'b0;
        chk("ign_out",   32'(if4.eight_output), 32'h02);
        chk("ign_count", 32'(if4.event_count),  32'(exp_cnt4));
        tick(); tick();
        chk("ign_out2",  32'(if4.eight_output), 32'h02);
        tick();
        chk("ign_end_V", 32'(if4.V),            32'd0);
        chk("ign_count2", 32'(if4.event_count), 32'd3);

        // reset in the 2nd hold cycle of code 7
        if4.three_input = 3'd7; if4.V_in = 1'b1;
        repeat (2) q4.push_back(8'h80);
        $display("txn dut4 abort code=7 expect=80");
        tick();
        if4.V_in = 1'b0;
        chk("abort_out1", 32'(if4.eight_output), 32'h80);
        tick();
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        exp_cnt4 = 0;
        chk("abort_out",   32'(if4.eight_output), 32'h00);
        chk("abort_V",     32'(if4.V),            32'd0);
        chk("abort_count", 32'(if4.event_count),  32'd0);

        // 256 back-to-back acceptances with single-cycle hold
        if1.V_in = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if1.three_input = 3'(i % 8);
            q1.push_back(exp_tab[i % 8]);
            $display("txn dut1 wrap n=%0d code=%0d expect=%02h", i, i % 8, exp_tab[i % 8]);
            tick();
            chk("wrap_V",     32'(if1.V),            32'd1);
            chk("wrap_ready", 32'(if1.in_ready),     32'd1);
            chk("wrap_out",   32'(if1.eight_output), 32'(exp_tab[i % 8]));
            chk("wrap_count", 32'(if1.event_count),  32'((i + 1) % 256));
        end
        if1.V_in = 1'b0;
        chk("wrap_final_count", 32'(if1.event_count), 32'd0);
        tick();
        chk("wrap_end_V", 32'(if1.V), 32'd0);

        tick(); tick();
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
